mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (M_ADDR / M_WE / M_WR_DATA / M_RD_DATA / M_RD_VALID) between two four-phase req/ack requesters.
- Port I is instruction fetch (read-only); port D is the mem stage (read or write).
- Sequences each RAM access: issue, wait for M_RD_VALID, return data on the channel ack.
- Sits between the fetch/mem pipeline stages and the external RAM.

Parameters:
PRIO_MODE, 1, 0 = fixed priority to D; 1 = round-robin between I and D
TIMEOUT, 16, max WAIT cycles for M_RD_VALID before forced completion (>=2)
RESET_DATA, 32'h00000000, value returned on timeout

Ports:
M_CLK  in  1  clock; all logic on rising edge
Z_R  in  1  synchronous active-high reset
i_R  in  1  fetch request
i_A  out  1  fetch acknowledge
i_ADDR  in  32  fetch address
i_RD_DATA  out  32  fetched word, valid while i_A=1
d_R  in  1  mem-stage request
d_A  out  1  mem-stage acknowledge
d_ADDR  in  32  mem-stage address
d_WR_DATA  in  32  store data
d_WE  in  1  1 = write, 0 = read
d_RD_DATA  out  32  load data, valid while d_A=1
M_ADDR  out  32  RAM address
M_WE  out  1  RAM write enable
M_WR_DATA  out  32  RAM write data
M_RD_DATA  in  32  RAM read data
M_RD_VALID  in  1  RAM access complete
GRANT  out  1  port being/last served: 0 = I, 1 = D
ERR  out  1  sticky timeout flag

Behaviour:
- Reset (Z_R=1 sampled at an edge):
  - All outputs go to 0.
  - State goes to IDLE; last-served is set to I; timeout counter is cleared.
  - Reset applies from any state. An in-flight access is abandoned with no ack; the requester must drop R and retry.
- Requester contract:
  - Address and data are stable while R=1.
  - R falls only after A=1; R rises again only after A=0.
- State machine: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - At edge E0, pick a winner among asserted R.
  - If only one R is asserted, that port wins.
  - If both are asserted: with PRIO_MODE=0, D wins; with PRIO_MODE=1, the port not last served wins.
  - On a win: register M_ADDR from the winner's address.
  - If the winner is D: M_WE=d_WE and M_WR_DATA=d_WR_DATA.
  - If the winner is I: M_WE=0 and M_WR_DATA is unchanged.
  - Update GRANT, then go to ISSUE.
  - With no request, remain in IDLE with M_WE=0; M_ADDR holds.
- ISSUE (one cycle):
  - The RAM samples the command at edge E1.
  - At E1: M_WE goes to 0 (write pulse is exactly one cycle), counter is cleared, go to WAIT.
- WAIT:
  - At each edge from E2 on, sample M_RD_VALID.
  - If 1: capture M_RD_DATA into the winner's RD_DATA, assert the winner's A, go to ACK.
  - For writes, RD_DATA is also updated (don't-care to the requester).
  - If 0: increment the counter.
  - When the counter reaches TIMEOUT: load RESET_DATA into RD_DATA, assert A, set ERR, go to ACK.
  - M_ADDR holds throughout WAIT.
- ACK:
  - A stays 1 while the winner's R=1.
  - On the edge sampling R=0: A goes to 0, last-served is set to the winner, go to IDLE.
  - The next grant is decided at the following edge, so the minimum gap between acks is 5 edges.
- Latency: R sampled at E0 -> A high after E2 (3 edges) when RAM responds in one cycle.
- The loser's request stays pending and is not lost; the loser's A and RD_DATA are untouched.
- RD_DATA holds its value until the next completion on the same port.
- ERR is cleared only by reset.
- Addresses pass through unmodified, full 32 bits; no alignment check.

Test Plan:
- D write d_ADDR=1, d_WR_DATA=0x101, d_WE=1 -> M_WE high exactly one cycle with M_ADDR=1, M_WR_DATA=0x101; d_A rises 3 edges after d_R is sampled; RAM word 1 = 0x101.
- Then I read i_ADDR=1 -> M_WE stays 0; i_RD_DATA=0x101 while i_A=1; GRANT=0.
- Round-robin: PRIO_MODE=1, i_R and d_R both held continuously after reset, 4 transactions -> served D, I, D, I.
- Fixed priority: PRIO_MODE=0 with the same stimulus -> D served repeatedly; I served only after d_R stays low.
- Timeout: TIMEOUT=8, M_RD_VALID forced 0 during a D read -> d_A after 8 WAIT cycles; d_RD_DATA=0; ERR=1 and stays 1 across later good accesses until Z_R.
- Reset in WAIT: Z_R pulsed for one cycle -> next edge i_A=d_A=0, M_WE=0, ERR=0, GRANT=0, state IDLE; a retried request completes normally.
- Held request: R held 10 cycles after A -> A stays 1, no new RAM command (M_WE=0, M_ADDR unchanged); R dropped -> A=0 next edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/mem) arbiter sharing one RAM port
// Sequences IDLE -> ISSUE -> WAIT -> ACK with four-phase req/ack on each requester.
module mem_port_arbiter #(
    parameter int          PRIO_MODE  = 1,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
    input  logic        M_CLK,
    input  logic        Z_R,
    input  logic        i_R,
    output logic        i_A,
    input  logic [31:0] i_ADDR,
    output logic [31:0] i_RD_DATA,
    input  logic        d_R,
    output logic        d_A,
    input  logic [31:0] d_ADDR,
    input  logic [31:0] d_WR_DATA,
    input  logic        d_WE,
    output logic [31:0] d_RD_DATA,
    output logic [31:0] M_ADDR,
    output logic        M_WE,
    output logic [31:0] M_WR_DATA,
    input  logic [31:0] M_RD_DATA,
    input  logic        M_RD_VALID,
    output logic        GRANT,
    output logic        ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic          m_we_q, m_we_d;
    logic [31:0]   m_wr_data_q, m_wr_data_d;
    logic          i_a_q, i_a_d;
    logic          d_a_q, d_a_d;
    logic [31:0]   i_rd_data_q, i_rd_data_d;
    logic [31:0]   d_rd_data_q, d_rd_data_d;
    logic          err_q, err_d;

    logic          pick_d;
    logic          done;
    logic [31:0]   done_data;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        m_addr_d    = m_addr_q;
        m_we_d      = m_we_q;
        m_wr_data_d = m_wr_data_q;
        i_a_d       = i_a_q;
        d_a_d       = d_a_q;
        i_rd_data_d = i_rd_data_q;
        d_rd_data_d = d_rd_data_q;
        err_d       = err_q;
        pick_d      = 1'b0;
        done        = 1'b0;
        done_data   = RESET_DATA;

        case (state_q)
            S_IDLE: begin
                m_we_d = 1'b0;
                // D wins when alone, under fixed priority, or when I was served last
                pick_d = d_R && (!i_R || (PRIO_MODE == 0) || !last_q);
                if (i_R || d_R) begin
                    grant_d  = pick_d;
                    m_addr_d = pick_d ? d_ADDR : i_ADDR;
                    if (pick_d) begin
                        m_we_d      = d_WE;
                        m_wr_data_d = d_WR_DATA;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_we_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (M_RD_VALID) begin
                    done      = 1'b1;
                    done_data = M_RD_DATA;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    done_data = RESET_DATA;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (done) begin
                    if (grant_q) begin
                        d_a_d       = 1'b1;
                        d_rd_data_d = done_data;
                    end else begin
                        i_a_d       = 1'b1;
                        i_rd_data_d = done_data;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (grant_q ? !d_R : !i_R) begin
                    i_a_d   = 1'b0;
                    d_a_d   = 1'b0;
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge M_CLK) begin
        if (Z_R) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            m_addr_q    <= '0;
            m_we_q      <= 1'b0;
            m_wr_data_q <= '0;
            i_a_q       <= 1'b0;
            d_a_q       <= 1'b0;
            i_rd_data_q <= '0;
            d_rd_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            m_addr_q    <= m_addr_d;
            m_we_q      <= m_we_d;
            m_wr_data_q <= m_wr_data_d;
            i_a_q       <= i_a_d;
            d_a_q       <= d_a_d;
            i_rd_data_q <= i_rd_data_d;
            d_rd_data_q <= d_rd_data_d;
            err_q       <= err_d;
        end
    end

    assign i_A       = i_a_q;
    assign d_A       = d_a_q;
    assign i_RD_DATA = i_rd_data_q;
    assign d_RD_DATA = d_rd_data_q;
    assign M_ADDR    = m_addr_q;
    assign M_WE      = m_we_q;
    assign M_WR_DATA = m_wr_data_q;
    assign GRANT     = grant_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        z_r = 1'b1;
    logic        ram_init = 1'b0;
    logic        ram_ok = 1'b1;

    logic        i_r = 1'b0, d_r = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wr_data = '0;
    logic        i_a, d_a, m_we, grant, err, m_rd_valid;
    logic [31:0] i_rd, d_rd, m_addr, m_wr_data, m_rd_data;

    logic        i_r2 = 1'b0, d_r2 = 1'b0;
    logic        i_a2, d_a2, m_we2, grant2, err2;
    logic [31:0] i_rd2, d_rd2, m_addr2, m_wr_data2, m_rd_data2;

    logic [31:0] mem [16];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'hA000 + 32'(k);
        end else if (m_we) begin
            mem[m_addr[3:0]] <= m_wr_data;
        end
    end

    assign m_rd_data  = mem[m_addr[3:0]];
    assign m_rd_valid = ram_ok;
    assign m_rd_data2 = m_addr2;

    mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT(8), .RESET_DATA(32'h0)) dut (
        .M_CLK(clk), .Z_R(z_r),
        .i_R(i_r), .i_A(i_a), .i_ADDR(i_addr), .i_RD_DATA(i_rd),
        .d_R(d_r), .d_A(d_a), .d_ADDR(d_addr), .d_WR_DATA(d_wr_data), .d_WE(d_we), .d_RD_DATA(d_rd),
        .M_ADDR(m_addr), .M_WE(m_we), .M_WR_DATA(m_wr_data), .M_RD_DATA(m_rd_data), .M_RD_VALID(m_rd_valid),
        .GRANT(grant), .ERR(err)
    );

    mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT(16), .RESET_DATA(32'h0)) dut_fix (
        .M_CLK(clk), .Z_R(z_r),
        .i_R(i_r2), .i_A(i_a2), .i_ADDR(32'h20), .i_RD_DATA(i_rd2),
        .d_R(d_r2), .d_A(d_a2), .d_ADDR(32'h30), .d_WR_DATA(32'h0), .d_WE(1'b0), .d_RD_DATA(d_rd2),
        .M_ADDR(m_addr2), .M_WE(m_we2), .M_WR_DATA(m_wr_data2), .M_RD_DATA(m_rd_data2), .M_RD_VALID(1'b1),
        .GRANT(grant2), .ERR(err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack0(output int t);
        t = 0;
        do begin
            step();
            t++;
        end while (!(i_a || d_a) && t < 40);
    endtask

    task automatic wait_ack1(output int t);
        t = 0;
        do begin
            step();
            t++;
        end while (!(i_a2 || d_a2) && t < 40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   t;
        logic exp_d;

        // reset state
        ram_init = 1'b1;
        step();
        step();
        ram_init = 1'b0;
        z_r = 1'b0;
        chk("rst_iA", i_a, 1'b0);
        chk("rst_dA", d_a, 1'b0);
        chk("rst_mwe", m_we, 1'b0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_err", err, 1'b0);

        // D write: one-cycle write pulse, ack three edges after request
        d_r = 1'b1; d_addr = 32'h1; d_wr_data = 32'h101; d_we = 1'b1;
        step();
        chk("wr_mwe_e0", m_we, 1'b1);
        chk("wr_maddr", m_addr, 32'h1);
        chk("wr_wdata", m_wr_data, 32'h101);
        chk("wr_grant", grant, 1'b1);
        step();
        chk("wr_mwe_e1", m_we, 1'b0);
        chk("wr_dA_e1", d_a, 1'b0);
        step();
        chk("wr_dA_e2", d_a, 1'b1);
        chk("wr_ram", mem[1], 32'h101);
        d_r = 1'b0; d_we = 1'b0;
        step();
        chk("wr_dA_drop", d_a, 1'b0);

        // I read of the written word, then R held for 10 cycles
        i_r = 1'b1; i_addr = 32'h1;
        wait_ack0(t);
        chk("rd_lat", t, 3);
        chk("rd_iA", i_a, 1'b1);
        chk("rd_data", i_rd, 32'h101);
        chk("rd_grant", grant, 1'b0);
        for (int n = 0; n < 10; n++) begin
            step();
            chk("hold_iA", i_a, 1'b1);
            chk("hold_mwe", m_we, 1'b0);
            chk("hold_maddr", m_addr, 32'h1);
        end
        i_r = 1'b0;
        step();
        chk("hold_drop", i_a, 1'b0);
        chk("rd_data_hold", i_rd, 32'h101);

        // round-robin with both requests held: D, I, D, I
        z_r = 1'b1;
        step();
        z_r = 1'b0;
        i_addr = 32'h2; d_addr = 32'h3;
        i_r = 1'b1; d_r = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack0(t);
            exp_d = (n % 2 == 0);
            chk("rr_lat", t, 3);
            chk("rr_grant", grant, exp_d);
            chk("rr_dA", d_a, exp_d);
            chk("rr_iA", i_a, !exp_d);
            chk("rr_data", exp_d ? d_rd : i_rd, exp_d ? 32'hA003 : 32'hA002);
            if (d_a) d_r = 1'b0; else i_r = 1'b0;
            step();
            chk("rr_drop", i_a | d_a, 1'b0);
            if (n < 3) begin
                i_r = 1'b1; d_r = 1'b1;
            end
        end
        i_r = 1'b0; d_r = 1'b0;
        step();

        // fixed priority: D, D, D, then I once d_r stays low
        i_r2 = 1'b1; d_r2 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack1(t);
            exp_d = (n < 3);
            chk("fp_grant", grant2, exp_d);
            chk("fp_dA", d_a2, exp_d);
            chk("fp_iA", i_a2, !exp_d);
            if (d_a2) d_r2 = 1'b0; else i_r2 = 1'b0;
            step();
            chk("fp_drop", i_a2 | d_a2, 1'b0);
            if (n < 2) d_r2 = 1'b1;
        end
        chk("fp_i_data", i_rd2, 32'h20);

        // timeout on a D read
        ram_ok = 1'b0;
        d_addr = 32'h5; d_we = 1'b0; d_r = 1'b1;
        wait_ack0(t);
        chk("to_lat", t, 10);
        chk("to_dA", d_a, 1'b1);
        chk("to_data", d_rd, 32'h0);
        chk("to_err", err, 1'b1);
        d_r = 1'b0; ram_ok = 1'b1;
        step();
        i_addr = 32'h5; i_r = 1'b1;
        wait_ack0(t);
        chk("to_good_data", i_rd, 32'hA005);
        chk("to_err_sticky", err, 1'b1);
        i_r = 1'b0;
        step();

        // reset while in WAIT, then retry
        ram_ok = 1'b0;
        d_addr = 32'h6; d_r = 1'b1;
        step();
        step();
        step();
        z_r = 1'b1;
        step();
        z_r = 1'b0;
        chk("rw_iA", i_a, 1'b0);
        chk("rw_dA", d_a, 1'b0);
        chk("rw_mwe", m_we, 1'b0);
        chk("rw_err", err, 1'b0);
        chk("rw_grant", grant, 1'b0);
        chk("rw_drd", d_rd, 32'h0);
        d_r = 1'b0;
        step();
        ram_ok = 1'b1;
        d_r = 1'b1;
        wait_ack0(t);
        chk("rw_retry_lat", t, 3);
        chk("rw_retry_data", d_rd, 32'hA006);
        chk("rw_retry_err", err, 1'b0);
        d_r = 1'b0;
        step();
        chk("rw_retry_drop", d_a, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
